// File: rtl/m_data_mem.sv
// ---------------------------------------------------------------------------
// m_data_mem
// Data memory for the pipeline's memory stage: 1024 x 32-bit words covering
// byte addresses 0x000-0xFFF, little-endian byte lanes.
// Loads are combinational (zero-latency) and extended according to MemOp.
// Stores commit on the rising clock edge, touching only the addressed lanes.
// Reset clears the whole array and the store counter asynchronously.
//
// Ports
//   clk       in   1  clock, storage updates on rising edge
//   rst_n     in   1  asynchronous active-low reset
//   MemWrite  in   1  store request this cycle
//   MemRead   in   1  load request this cycle
//   MemOp     in   3  000 word, 001 half signed, 010 half unsigned,
//                     011 byte signed, 100 byte unsigned, 101-111 reserved
//   Addr      in  32  byte address
//   WData     in  32  right-aligned store data
//   RData     out 32  extended load data (0 when idle or faulting)
//   AdEL      out  1  load address exception
//   AdES      out  1  store address exception
//   StoreCnt  out 16  number of committed stores (wraps)
// ---------------------------------------------------------------------------
module m_data_mem (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [2:0]  MemOp,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    output logic [31:0] RData,
    output logic        AdEL,
    output logic        AdES,
    output logic [15:0] StoreCnt
);

    localparam logic [2:0] OP_WORD = 3'b000;
    localparam logic [2:0] OP_HS   = 3'b001;
    localparam logic [2:0] OP_HU   = 3'b010;
    localparam logic [2:0] OP_BS   = 3'b011;
    localparam logic [2:0] OP_BU   = 3'b100;

    logic [31:0] mem_q [1024];
    logic [15:0] store_cnt_q;
    logic [15:0] store_cnt_d;
    logic [31:0] wr_word_d;

    logic        out_of_range;
    logic        misaligned;
    logic        reserved_op;
    logic        addr_err;
    logic        store_en;
    logic [9:0]  word_idx;
    logic [31:0] rd_word;
    logic [15:0] ld_half;
    logic [7:0]  ld_byte;
    logic [31:0] ext_data;
    logic [3:0]  lane_mask;
    logic [31:0] lane_data;

    // Address checks are shared by loads and stores; each flag is then
    // qualified by its own request so a combined access reports independently.
    always_comb begin
        out_of_range = |Addr[31:12];
        reserved_op  = (MemOp > OP_BU);
        misaligned   = 1'b0;
        case (MemOp)
            OP_WORD:      misaligned = |Addr[1:0];
            OP_HS, OP_HU: misaligned = Addr[0];
            default:      misaligned = 1'b0;
        endcase
        addr_err = out_of_range | misaligned | reserved_op;
        AdEL     = MemRead  & addr_err;
        AdES     = MemWrite & addr_err;
        store_en = MemWrite & ~addr_err;
    end

    // Load path reads the array as it stands before this cycle's edge, so a
    // same-cycle load of a word being stored sees the old contents.
    always_comb begin
        word_idx = Addr[11:2];
        rd_word  = mem_q[word_idx];
        ld_half  = Addr[1] ? rd_word[31:16] : rd_word[15:0];
        ld_byte  = rd_word[8*Addr[1:0] +: 8];
        ext_data = '0;
        case (MemOp)
            OP_WORD: ext_data = rd_word;
            OP_HS:   ext_data = {{16{ld_half[15]}}, ld_half};
            OP_HU:   ext_data = {16'h0000, ld_half};
            OP_BS:   ext_data = {{24{ld_byte[7]}}, ld_byte};
            OP_BU:   ext_data = {24'h000000, ld_byte};
            default: ext_data = '0;
        endcase
        RData = (MemRead && !AdEL) ? ext_data : '0;
    end

    // Store data is replicated across lanes and the mask picks which lanes
    // replace the current word; untouched lanes keep their old bytes.
    always_comb begin
        lane_mask = 4'b0000;
        lane_data = WData;
        case (MemOp)
            OP_WORD: begin
                lane_mask = 4'b1111;
                lane_data = WData;
            end
            OP_HS, OP_HU: begin
                lane_mask = Addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{WData[15:0]}};
            end
            OP_BS, OP_BU: begin
                lane_mask = 4'b0001 << Addr[1:0];
                lane_data = {4{WData[7:0]}};
            end
            default: lane_mask = 4'b0000;
        endcase
        for (int b = 0; b < 4; b++) begin
            wr_word_d[8*b +: 8] = lane_mask[b] ? lane_data[8*b +: 8]
                                               : rd_word[8*b +: 8];
        end
        store_cnt_d = store_en ? store_cnt_q + 16'd1 : store_cnt_q;
    end

    // Reset wins over any store on the same edge, so an abandoned store
    // leaves the array fully cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 1024; i++) begin
                mem_q[i] <= '0;
            end
            store_cnt_q <= '0;
        end else begin
            if (store_en) begin
                mem_q[word_idx] <= wr_word_d;
            end
            store_cnt_q <= store_cnt_d;
        end
    end

    assign StoreCnt = store_cnt_q;

endmodule

// File: doc/m_data_mem.md
M_DATA_MEM -- requirements
Module: m_data_mem

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all storage updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port MemWrite, input, 1 bit: store request this cycle.
REQ-004 SHALL have port MemRead, input, 1 bit: load request this cycle.
REQ-005 SHALL have port MemOp, input, 3 bits: access type. 000 word; 001 half signed; 010 half unsigned; 011 byte signed; 100 byte unsigned; 101-111 reserved.
REQ-006 SHALL have port Addr, input, 32 bits: byte address, driven by the execute-stage ALU result.
REQ-007 SHALL have port WData, input, 32 bits: store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-008 SHALL have port RData, output, 32 bits: extended load data.
REQ-009 SHALL have port AdEL, output, 1 bit: load address exception.
REQ-010 SHALL have port AdES, output, 1 bit: store address exception.
REQ-011 SHALL have port StoreCnt, output, 16 bits: count of committed stores.

Function
REQ-012 SHALL hold 1024 x 32-bit words covering byte addresses 0x0000_0000-0x0000_0FFF; word index is Addr[11:2]; byte lanes are little-endian (Addr[1:0]=0 selects bits [7:0]).
REQ-013 SHALL flag an address out of range when Addr[31:12] != 0.
REQ-014 SHALL flag misalignment: word access with Addr[1:0] != 0; half access with Addr[0] != 0; byte accesses are never misaligned.
REQ-015 SHALL drive AdEL = MemRead & (out of range | misaligned | reserved MemOp), combinationally.
REQ-016 SHALL drive AdES = MemWrite & (out of range | misaligned | reserved MemOp), combinationally.
REQ-017 SHALL commit a store on the rising clk edge only when MemWrite=1, AdES=0 and rst_n=1; only the addressed lanes change: word writes all 4 bytes, half writes bytes {Addr[1],0}..{Addr[1],1}, byte writes byte Addr[1:0].
REQ-018 SHALL leave all memory and StoreCnt unchanged on a store with AdES=1.
REQ-019 SHALL read combinationally (zero-latency) from the current array contents: a load in the cycle after a store returns the new data; a load in the same cycle as a store to the same word returns the pre-store data.
REQ-020 SHALL extend loads: half signed uses bit 15 of the selected half; half unsigned zero-fills; byte signed uses bit 7 of the selected byte; byte unsigned zero-fills; word is passed unchanged.
REQ-021 SHALL drive RData = 0 when MemRead=0 or AdEL=1.
REQ-022 SHALL treat MemRead=1 and MemWrite=1 together as both operations, with independent exception flags and REQ-019 ordering.
REQ-023 SHALL increment StoreCnt by 1 per committed store, wrapping from 0xFFFF to 0x0000.

Reset
REQ-024 SHALL, while rst_n=0, asynchronously clear all 1024 words and StoreCnt to 0, and block stores.
REQ-025 SHALL abandon a store whose edge coincides with rst_n=0; after release, all words read 0.
REQ-026 SHALL resume normal operation on the first rising clk edge after rst_n returns to 1.

Verification
REQ-027 SHALL check word store then load: sw 0xDEADBEEF at 0x10, next cycle lw 0x10 -> RData=0xDEADBEEF, StoreCnt=1.
REQ-028 SHALL check sub-word stores and extended loads: sw 0 at 0x20; sb 0x80 at 0x21; sh 0x8001 at 0x22. Expected reads: lw 0x20 -> 0x80018000; lb 0x21 -> 0xFFFFFF80; lbu 0x21 -> 0x00000080; lh 0x22 -> 0xFFFF8001; lhu 0x22 -> 0x00008001.
REQ-029 SHALL check exceptions: sw at 0x13 -> AdES=1, word 0x10 unchanged, StoreCnt unchanged; lh at 0x21 -> AdEL=1, RData=0; lw at 0x1000 -> AdEL=1; MemOp=101 load -> AdEL=1.
REQ-030 SHALL check same-cycle store/load to 0x40 (old value 0x11111111, new 0x22222222): RData=0x11111111 in that cycle, 0x22222222 in the next cycle.
REQ-031 SHALL check reset mid-operation: after stores at 0x0 and 0xFFC, assert rst_n=0 asynchronously between edges -> StoreCnt=0 immediately; after release, lw 0x0 and lw 0xFFC both -> 0.
REQ-032 SHALL check StoreCnt wrap: 65536 committed stores -> StoreCnt returns to 0x0000.
